// File: rtl/dm_arb_pkg.sv
// -----------------------------------------------------------------------------
// dm_arb_pkg
// Shared types and constants for the data-memory arbiter.
//   arb_state_t : arbiter FSM state (records the last owner of dm)
//   DM_*        : data-memory access types, shared with the dm block
//   STARVE_W    : width of the DMA starvation counter
// -----------------------------------------------------------------------------
package dm_arb_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CPU      = 2'd1,
    DMA      = 2'd2,
    DMA_LOCK = 2'd3
  } arb_state_t;

  // Access types understood by dm (size and sign extension of loads).
  localparam logic [2:0] DM_WORD   = 3'd0;
  localparam logic [2:0] DM_HALF   = 3'd1;
  localparam logic [2:0] DM_HALF_U = 3'd2;
  localparam logic [2:0] DM_BYTE   = 3'd3;
  localparam logic [2:0] DM_BYTE_U = 3'd4;

  localparam int STARVE_W = 8;

endpackage

// File: rtl/dm_arbiter_if.sv
// -----------------------------------------------------------------------------
// dm_arbiter_if
// Bundles the CPU load/store port, the DMA/loader port and the dm port of the
// arbiter.
//   cpu_* : CPU request (req/we/addr/wdata/dmtype) and response (gnt/rvalid/rdata)
//   dma_* : DMA request, same meaning as cpu_*, plus dma_lock for bursts
//   dm_*  : memory strobe/address/write data/type out, dm_dout read data in
// Modports:
//   slave  : the arbiter
//   master : the environment (CPU, DMA and dm together)
// -----------------------------------------------------------------------------
interface dm_arbiter_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
);

  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [2:0]        cpu_dmtype;
  logic              cpu_gnt;
  logic              cpu_rvalid;
  logic [DATA_W-1:0] cpu_rdata;

  logic              dma_req;
  logic              dma_we;
  logic [ADDR_W-1:0] dma_addr;
  logic [DATA_W-1:0] dma_wdata;
  logic [2:0]        dma_dmtype;
  logic              dma_lock;
  logic              dma_gnt;
  logic              dma_rvalid;
  logic [DATA_W-1:0] dma_rdata;

  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_din;
  logic [2:0]        dm_dmtype;
  logic [DATA_W-1:0] dm_dout;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_dmtype,
    output cpu_gnt, cpu_rvalid, cpu_rdata,
    input  dma_req, dma_we, dma_addr, dma_wdata, dma_dmtype, dma_lock,
    output dma_gnt, dma_rvalid, dma_rdata,
    output dm_we, dm_addr, dm_din, dm_dmtype,
    input  dm_dout
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_dmtype,
    input  cpu_gnt, cpu_rvalid, cpu_rdata,
    output dma_req, dma_we, dma_addr, dma_wdata, dma_dmtype, dma_lock,
    input  dma_gnt, dma_rvalid, dma_rdata,
    input  dm_we, dm_addr, dm_din, dm_dmtype,
    output dm_dout
  );

endinterface

// File: rtl/dm_arb_starve.sv
// -----------------------------------------------------------------------------
// dm_arb_starve
// Saturating count of consecutive cycles in which the DMA port requested but
// was not granted. force_dma tells the arbiter to hand the next contended
// cycle to DMA.
// Ports:
//   clk, rstn  : clock, synchronous active-low reset
//   dma_req    : DMA is requesting this cycle
//   dma_gnt    : DMA was granted this cycle
//   force_dma  : counter has reached STARVE_MAX
// -----------------------------------------------------------------------------
module dm_arb_starve
  import dm_arb_pkg::*;
#(
  parameter int STARVE_MAX = 8
) (
  input  logic clk,
  input  logic rstn,
  input  logic dma_req,
  input  logic dma_gnt,
  output logic force_dma
);

  logic [STARVE_W-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments and the reset is
  // tested inside the clocked block, so it only acts on a rising edge.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt <= '0;
    end else if (!dma_req || dma_gnt) begin
      cnt <= '0;
    end else if (cnt != '1) begin
      cnt <= cnt + STARVE_W'(1);
    end
  end

  assign force_dma = (cnt >= STARVE_W'(STARVE_MAX));

endmodule

// File: rtl/dm_arbiter.sv
// -----------------------------------------------------------------------------
// dm_arbiter
// Shares the single data memory between the CPU load/store port and a DMA /
// program-loader port. One access per cycle is issued to dm; read data is
// registered and returned one cycle after the grant to the port that issued
// the read. A deasserted cpu_gnt stalls the CPU.
// Ports:
//   clk   : system clock
//   rstn  : synchronous active-low reset
//   bus   : dm_arbiter_if.slave (cpu_*, dma_*, dm_* signal groups)
// Parameters:
//   ADDR_W, DATA_W : must match the interface instance
//   STARVE_MAX     : denied DMA cycles before DMA is forced in (1..255)
// Configuration:
//   DM_ARB_RR_EN   : defined -> round-robin under contention;
//                    undefined -> fixed CPU priority, DMA only via starvation.
// -----------------------------------------------------------------------------
module dm_arbiter
  import dm_arb_pkg::*;
#(
  parameter int ADDR_W     = 9,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 8
) (
  input  logic         clk,
  input  logic         rstn,
  dm_arbiter_if.slave  bus
);

  arb_state_t        state, next_state;
  logic              cpu_gnt, dma_gnt;
  logic              force_dma;
  logic [ADDR_W-1:0] dm_addr;
  logic [ADDR_W-1:0] addr_q;
  logic              cpu_rd, dma_rd;
  logic              cpu_rvalid_q, dma_rvalid_q;
  logic [DATA_W-1:0] cpu_rdata_q, dma_rdata_q;

  dm_arb_starve #(.STARVE_MAX(STARVE_MAX)) u_starve (
    .clk       (clk),
    .rstn      (rstn),
    .dma_req   (bus.dma_req),
    .dma_gnt   (dma_gnt),
    .force_dma (force_dma)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rstn) state <= IDLE;
    else       state <= next_state;
  end

  // Grant decode. A held lock beats everything; the starvation force beats
  // the contention policy but never an active lock.
  always_comb begin
    // NOTE: defaults first so every path assigns both grants; no latches.
    cpu_gnt = 1'b0;
    dma_gnt = 1'b0;
    if (state == DMA_LOCK && bus.dma_req) begin
      dma_gnt = 1'b1;
    end else if (bus.cpu_req && bus.dma_req) begin
      if (force_dma) begin
        dma_gnt = 1'b1;
      end else begin
`ifdef DM_ARB_RR_EN
        // The port that did not own dm last wins.
        if (state == CPU) dma_gnt = 1'b1;
        else              cpu_gnt = 1'b1;
`else
        cpu_gnt = 1'b1;
`endif
      end
    end else begin
      cpu_gnt = bus.cpu_req;
      dma_gnt = bus.dma_req;
    end
  end

  // Next state: remember the owner; leaving a lock always passes via IDLE.
  always_comb begin
    next_state = IDLE;
    if (dma_gnt && bus.dma_lock) next_state = DMA_LOCK;
    else if (state == DMA_LOCK)  next_state = IDLE;
    else if (cpu_gnt)            next_state = CPU;
    else if (dma_gnt)            next_state = DMA;
  end

  // Memory port mux. The address holds across idle cycles so dm_dout does
  // not toggle needlessly.
  assign dm_addr       = dma_gnt ? bus.dma_addr : (cpu_gnt ? bus.cpu_addr : addr_q);
  assign bus.dm_addr   = dm_addr;
  assign bus.dm_we     = (cpu_gnt & bus.cpu_we) | (dma_gnt & bus.dma_we);
  assign bus.dm_din    = dma_gnt ? bus.dma_wdata  : bus.cpu_wdata;
  assign bus.dm_dmtype = dma_gnt ? bus.dma_dmtype : bus.cpu_dmtype;

  assign cpu_rd = cpu_gnt & ~bus.cpu_we;
  assign dma_rd = dma_gnt & ~bus.dma_we;

  // Read return: capture dm_dout at the grant edge for the issuing port.
  // Reset squashes any pending rvalid.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      addr_q       <= '0;
      cpu_rvalid_q <= 1'b0;
      dma_rvalid_q <= 1'b0;
      cpu_rdata_q  <= '0;
      dma_rdata_q  <= '0;
    end else begin
      if (cpu_gnt || dma_gnt) addr_q <= dm_addr;
      cpu_rvalid_q <= cpu_rd;
      dma_rvalid_q <= dma_rd;
      if (cpu_rd) cpu_rdata_q <= bus.dm_dout;
      if (dma_rd) dma_rdata_q <= bus.dm_dout;
    end
  end

  assign bus.cpu_gnt    = cpu_gnt;
  assign bus.dma_gnt    = dma_gnt;
  assign bus.cpu_rvalid = cpu_rvalid_q;
  assign bus.dma_rvalid = dma_rvalid_q;
  assign bus.cpu_rdata  = cpu_rdata_q;
  assign bus.dma_rdata  = dma_rdata_q;

endmodule

// File: tb/tb_dm_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dm_arbiter
// Self-checking bench for dm_arbiter with STARVE_MAX = 4 and a behavioural
// byte-lane data memory. Contention expectations follow DM_ARB_RR_EN.
// -----------------------------------------------------------------------------
module tb_dm_arbiter;
  import dm_arb_pkg::*;

  localparam int AW = 9;
  localparam int DW = 32;

  logic clk;
  logic rstn;
  int   n_checks = 0;
  int   n_fail   = 0;

  dm_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  dm_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(4)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural dm: combinational read, byte-lane writes on the rising edge.
  logic [31:0] mem [0:127];
  assign bus.dm_dout = mem[bus.dm_addr[8:2]];

  always @(posedge clk) begin
    if (bus.dm_we) begin
      case (bus.dm_dmtype)
        DM_BYTE, DM_BYTE_U: mem[bus.dm_addr[8:2]][8*bus.dm_addr[1:0] +: 8]  <= bus.dm_din[7:0];
        DM_HALF, DM_HALF_U: mem[bus.dm_addr[8:2]][16*bus.dm_addr[1] +: 16] <= bus.dm_din[15:0];
        default:            mem[bus.dm_addr[8:2]] <= bus.dm_din;
      endcase
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic c_req, input logic c_we, input logic [8:0] c_addr,
                       input logic [31:0] c_wdata, input logic [2:0] c_type,
                       input logic d_req, input logic d_we, input logic [8:0] d_addr,
                       input logic [31:0] d_wdata, input logic d_lock);
    bus.cpu_req    = c_req;
    bus.cpu_we     = c_we;
    bus.cpu_addr   = c_addr;
    bus.cpu_wdata  = c_wdata;
    bus.cpu_dmtype = c_type;
    bus.dma_req    = d_req;
    bus.dma_we     = d_we;
    bus.dma_addr   = d_addr;
    bus.dma_wdata  = d_wdata;
    bus.dma_dmtype = DM_WORD;
    bus.dma_lock   = d_lock;
  endtask

  task automatic idle();
    drive(0, 0, 9'h0, 32'h0, DM_WORD, 0, 0, 9'h0, 32'h0, 0);
  endtask

  // Step to the next cycle: inputs change 1 time unit after the rising edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        c_req, c_we;
    logic [8:0]  c_addr;
    logic [31:0] c_wdata;
    logic        d_req, d_we;
    logic [8:0]  d_addr;
    logic [31:0] d_wdata;
    logic        e_cgnt, e_dgnt, e_we;
    logic [8:0]  e_addr;
    logic        e_crv, e_drv;
    logic [31:0] e_rdata;
  } vec_t;

  vec_t vecs [8];

  initial begin
    logic e_d, p_d;

    for (int i = 0; i < 128; i++) mem[i] = 32'h0;
    mem[4] = 32'hDEADBEEF;  // byte address 0x010
    mem[8] = 32'h12345678;  // byte address 0x020

    //          c_req we addr    wdata         d_req we addr    wdata         cgnt dgnt we addr    crv drv rdata
    vecs[0] = '{1, 0, 9'h010, 32'h0,        0, 0, 9'h000, 32'h0,        1, 0, 0, 9'h010, 0, 0, 32'h0};
    vecs[1] = '{0, 0, 9'h000, 32'h0,        0, 0, 9'h000, 32'h0,        0, 0, 0, 9'h010, 1, 0, 32'hDEADBEEF};
    vecs[2] = '{0, 0, 9'h000, 32'h0,        1, 0, 9'h020, 32'h0,        0, 1, 0, 9'h020, 0, 0, 32'h0};
    vecs[3] = '{1, 1, 9'h030, 32'hCAFEF00D, 0, 0, 9'h000, 32'h0,        1, 0, 1, 9'h030, 0, 1, 32'h12345678};
    vecs[4] = '{1, 0, 9'h030, 32'h0,        0, 0, 9'h000, 32'h0,        1, 0, 0, 9'h030, 0, 0, 32'h0};
    vecs[5] = '{0, 0, 9'h000, 32'h0,        1, 0, 9'h030, 32'h0,        0, 1, 0, 9'h030, 1, 0, 32'hCAFEF00D};
    vecs[6] = '{0, 0, 9'h000, 32'h0,        1, 1, 9'h040, 32'h55AA55AA, 0, 1, 1, 9'h040, 0, 1, 32'hCAFEF00D};
    vecs[7] = '{0, 0, 9'h000, 32'h0,        0, 0, 9'h000, 32'h0,        0, 0, 0, 9'h040, 0, 0, 32'h0};

    // ---------------- reset state ----------------
    rstn = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst cpu_gnt",    bus.cpu_gnt,    0);
    check("rst dma_gnt",    bus.dma_gnt,    0);
    check("rst cpu_rvalid", bus.cpu_rvalid, 0);
    check("rst dma_rvalid", bus.dma_rvalid, 0);
    check("rst cpu_rdata",  bus.cpu_rdata,  0);
    check("rst dma_rdata",  bus.dma_rdata,  0);
    check("rst dm_we",      bus.dm_we,      0);
    check("rst dm_addr",    bus.dm_addr,    0);
    next_cycle();
    rstn = 1'b1;

    // ---------------- table-driven single-requester traffic ----------------
    foreach (vecs[i]) begin
      drive(vecs[i].c_req, vecs[i].c_we, vecs[i].c_addr, vecs[i].c_wdata, DM_WORD,
            vecs[i].d_req, vecs[i].d_we, vecs[i].d_addr, vecs[i].d_wdata, 0);
      @(negedge clk);
      check($sformatf("v%0d cpu_gnt", i),    bus.cpu_gnt,    vecs[i].e_cgnt);
      check($sformatf("v%0d dma_gnt", i),    bus.dma_gnt,    vecs[i].e_dgnt);
      check($sformatf("v%0d dm_we", i),      bus.dm_we,      vecs[i].e_we);
      check($sformatf("v%0d dm_addr", i),    bus.dm_addr,    vecs[i].e_addr);
      check($sformatf("v%0d cpu_rvalid", i), bus.cpu_rvalid, vecs[i].e_crv);
      check($sformatf("v%0d dma_rvalid", i), bus.dma_rvalid, vecs[i].e_drv);
      if (vecs[i].e_crv) check($sformatf("v%0d cpu_rdata", i), bus.cpu_rdata, vecs[i].e_rdata);
      if (vecs[i].e_drv) check($sformatf("v%0d dma_rdata", i), bus.dma_rdata, vecs[i].e_rdata);
      next_cycle();
    end

    // ---------------- continuous contention ----------------
    p_d = 1'b0;
    for (int i = 0; i < 10; i++) begin
`ifdef DM_ARB_RR_EN
      e_d = (i % 2) == 1;
`else
      e_d = (i % 5) == 4;
`endif
      drive(1, 0, 9'h010, 32'h0, DM_WORD, 1, 0, 9'h020, 32'h0, 0);
      @(negedge clk);
      check($sformatf("cont%0d cpu_gnt", i), bus.cpu_gnt, !e_d);
      check($sformatf("cont%0d dma_gnt", i), bus.dma_gnt, e_d);
      if (i > 0) begin
        check($sformatf("cont%0d cpu_rvalid", i), bus.cpu_rvalid, !p_d);
        check($sformatf("cont%0d dma_rvalid", i), bus.dma_rvalid, p_d);
        if (p_d) check($sformatf("cont%0d dma_rdata", i), bus.dma_rdata, 32'h12345678);
        else     check($sformatf("cont%0d cpu_rdata", i), bus.cpu_rdata, 32'hDEADBEEF);
      end
      p_d = e_d;
      next_cycle();
    end
    idle();
    next_cycle();

    // ---------------- DMA lock burst against a requesting CPU ----------------
    for (int k = 0; k < 6; k++) begin
      drive(k > 0, 0, 9'h010, 32'h0, DM_WORD,
            1, 1, 9'(9'h100 + 4 * k), 32'hA000_0000 + k, 1);
      @(negedge clk);
      check($sformatf("lock%0d dma_gnt", k), bus.dma_gnt, 1);
      check($sformatf("lock%0d cpu_gnt", k), bus.cpu_gnt, 0);
      check($sformatf("lock%0d dm_we", k),   bus.dm_we,   1);
      check($sformatf("lock%0d dm_addr", k), bus.dm_addr, 9'h100 + 4 * k);
      next_cycle();
    end
    drive(1, 0, 9'h010, 32'h0, DM_WORD, 0, 0, 9'h000, 32'h0, 0);
    @(negedge clk);
    check("unlock cpu_gnt", bus.cpu_gnt, 1);
    check("unlock dma_gnt", bus.dma_gnt, 0);
    next_cycle();
    idle();
    @(negedge clk);
    check("unlock cpu_rvalid", bus.cpu_rvalid, 1);
    check("unlock cpu_rdata",  bus.cpu_rdata,  32'hDEADBEEF);
    next_cycle();

    // Read the burst back through the DMA port.
    for (int k = 0; k <= 6; k++) begin
      if (k < 6) drive(0, 0, 9'h000, 32'h0, DM_WORD, 1, 0, 9'(9'h100 + 4 * k), 32'h0, 0);
      else       idle();
      @(negedge clk);
      if (k < 6) check($sformatf("rb%0d dma_gnt", k), bus.dma_gnt, 1);
      if (k > 0) begin
        check($sformatf("rb%0d dma_rvalid", k), bus.dma_rvalid, 1);
        check($sformatf("rb%0d dma_rdata", k),  bus.dma_rdata,  32'hA000_0000 + (k - 1));
      end
      next_cycle();
    end

    // ---------------- reset in the cycle after a locked DMA read ----------------
    drive(0, 0, 9'h000, 32'h0, DM_WORD, 1, 0, 9'h020, 32'h0, 1);
    @(negedge clk);
    check("rstmid dma_gnt", bus.dma_gnt, 1);
    next_cycle();
    rstn = 1'b0;
    drive(1, 1, 9'h050, 32'h0000_0077, DM_WORD, 0, 0, 9'h000, 32'h0, 0);
    @(negedge clk);
    check("rstcyc dma_rvalid", bus.dma_rvalid, 1);
    check("rstcyc dma_rdata",  bus.dma_rdata,  32'h12345678);
    check("rstcyc cpu_gnt",    bus.cpu_gnt,    1);
    check("rstcyc dm_we",      bus.dm_we,      1);
    check("rstcyc dm_addr",    bus.dm_addr,    9'h050);
    next_cycle();
    idle();
    @(negedge clk);
    check("postrst dma_rvalid", bus.dma_rvalid, 0);
    check("postrst cpu_rvalid", bus.cpu_rvalid, 0);
    check("postrst dma_rdata",  bus.dma_rdata,  0);
    check("postrst cpu_rdata",  bus.cpu_rdata,  0);
    check("postrst cpu_gnt",    bus.cpu_gnt,    0);
    check("postrst dma_gnt",    bus.dma_gnt,    0);
    check("postrst dm_we",      bus.dm_we,      0);
    check("postrst dm_addr",    bus.dm_addr,    0);
    next_cycle();
    rstn = 1'b1;
    // Lock must be gone: contention from IDLE goes to the CPU.
    drive(1, 0, 9'h010, 32'h0, DM_WORD, 1, 0, 9'h020, 32'h0, 1);
    @(negedge clk);
    check("nolock cpu_gnt", bus.cpu_gnt, 1);
    check("nolock dma_gnt", bus.dma_gnt, 0);
    next_cycle();

    // ---------------- write from the reset cycle, then byte store ----------------
    drive(1, 0, 9'h050, 32'h0, DM_WORD, 0, 0, 9'h000, 32'h0, 0);
    @(negedge clk);
    check("rd050 cpu_rvalid", bus.cpu_rvalid, 1);
    check("rd050 cpu_rdata",  bus.cpu_rdata,  32'hDEADBEEF);
    next_cycle();
    drive(1, 1, 9'h003, 32'h0000_00AB, DM_BYTE, 0, 0, 9'h000, 32'h0, 0);
    @(negedge clk);
    check("rstwr readback",   bus.cpu_rdata,  32'h0000_0077);
    check("byte dm_dmtype",   bus.dm_dmtype,  DM_BYTE);
    check("byte dm_we",       bus.dm_we,      1);
    check("byte dm_addr",     bus.dm_addr,    9'h003);
    next_cycle();
    idle();
    @(negedge clk);
    check("byte dm_we drop",  bus.dm_we,      0);
    check("byte no rvalid",   bus.cpu_rvalid, 0);
    next_cycle();
    drive(1, 0, 9'h000, 32'h0, DM_WORD, 0, 0, 9'h000, 32'h0, 0);
    next_cycle();
    idle();
    @(negedge clk);
    check("byte rb rvalid",   bus.cpu_rvalid, 1);
    check("byte rb rdata",    bus.cpu_rdata,  32'hAB00_0000);
    next_cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
